// File: rtl/tmdb_mpu_pkg.sv
// -----------------------------------------------------------------------------
// tmdb_mpu_pkg
// Shared constants for the MPU detect path: flag word width, default BCID
// counter geometry, threshold flag bit positions and the field layout of the
// serialised detect record {ch, bcid, flags}.
// -----------------------------------------------------------------------------
package tmdb_mpu_pkg;

  localparam int FLAG_W     = 4;
  localparam int BCID_W_DEF = 12;
  localparam int BC_MAX_DEF = 3563;

  // Threshold flag bit positions inside a detect flag word
  localparam int FLAG_LLT  = 0;
  localparam int FLAG_HLT  = 1;
  localparam int FLAG_SLLT = 2;
  localparam int FLAG_SHLT = 3;

  // Record field offsets: flags at the bottom, bcid above, channel on top
  localparam int FLAGS_LSB = 0;
  localparam int BCID_LSB  = FLAGS_LSB + FLAG_W;

  function automatic int ch_lsb(input int bcid_w);
    return BCID_LSB + bcid_w;
  endfunction

  function automatic int rec_w(input int n_ch, input int bcid_w);
    return $clog2(n_ch) + bcid_w + FLAG_W;
  endfunction

endpackage

// File: rtl/detect_arbiter_if.sv
// -----------------------------------------------------------------------------
// detect_arbiter_if
// Valid/ready record stream out of detect_arbiter.
//   o_valid : record valid (driven by master)
//   o_ready : downstream accept (driven by slave)
//   o_data  : {ch, bcid, flags} record (driven by master)
// -----------------------------------------------------------------------------
interface detect_arbiter_if #(
  parameter int N_CH   = 8,
  parameter int BCID_W = 12
);
  import tmdb_mpu_pkg::*;

  localparam int DATA_W = rec_w(N_CH, BCID_W);

  logic              o_valid;
  logic              o_ready;
  logic [DATA_W-1:0] o_data;

  modport master (output o_valid, output o_data, input  o_ready);
  modport slave  (input  o_valid, input  o_data, output o_ready);

endinterface

// File: rtl/detect_fifo.sv
// -----------------------------------------------------------------------------
// detect_fifo
// Small synchronous FIFO holding time-stamped detect entries for one channel.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and entry
//   pop        : read request; dout is the head entry whenever !empty
//   empty/full : occupancy status
// A push while full is accepted only when a pop happens in the same cycle.
// A pop while empty is ignored.
// -----------------------------------------------------------------------------
module detect_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same clock edge regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/detect_arbiter.sv
// -----------------------------------------------------------------------------
// detect_arbiter
// Time-stamps non-zero detect flag words from N_CH channels with the local
// BCID, buffers them per channel and serialises them by round-robin onto one
// valid/ready stream. Also keeps sticky overflow flags and a drop counter.
//   clk, rst_n : 40 MHz bunch clock, asynchronous active-low reset
//   det_flags  : 4-bit flag word per channel, channel k at [4k+3:4k]
//   ch_en      : per-channel enable
//   bcr        : bunch-counter reset pulse (bcid = 0 next cycle)
//   clr_stat   : clears ovf_flags / drop_cnt (same-cycle drops still count)
//   ovf_flags  : sticky per-channel overflow
//   drop_cnt   : saturating total of dropped records
//   stream     : record output {ch, bcid, flags}, valid/ready
// -----------------------------------------------------------------------------
module detect_arbiter
  import tmdb_mpu_pkg::*;
#(
  parameter int N_CH       = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BC_MAX     = BC_MAX_DEF,
  parameter int BCID_W     = BCID_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [FLAG_W*N_CH-1:0]   det_flags,
  input  logic [N_CH-1:0]          ch_en,
  input  logic                     bcr,
  input  logic                     clr_stat,
  output logic [N_CH-1:0]          ovf_flags,
  output logic [15:0]              drop_cnt,
  detect_arbiter_if.master         stream
);

  localparam int CHW   = $clog2(N_CH);
  localparam int ENT_W = BCID_W + FLAG_W;
  localparam int CNTW  = $clog2(N_CH + 1);

  logic [BCID_W-1:0]           bcid;
  logic [N_CH-1:0]             hit;
  logic [N_CH-1:0]             drop;
  logic [N_CH-1:0]             fifo_push;
  logic [N_CH-1:0]             fifo_pop;
  logic [N_CH-1:0]             fifo_empty;
  logic [N_CH-1:0]             fifo_full;
  logic [N_CH-1:0][ENT_W-1:0]  fifo_dout;
  logic [CHW-1:0]              rr;
  logic [CHW-1:0]              gnt_ch;
  logic                        gnt_found;
  logic                        load;
  logic [CNTW-1:0]             n_drop;
  logic [16:0]                 drop_sum;

  // ---------------------------------------------------------------------------
  // Bunch-crossing counter: bcr wins over wrap and increment
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcid <= '0;
    end else if (bcr) begin
      bcid <= '0;
    end else if (bcid == BCID_W'(BC_MAX)) begin
      bcid <= '0;
    end else begin
      bcid <= bcid + BCID_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel capture and buffering
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign hit[k]       = ch_en[k] && (det_flags[FLAG_W*k +: FLAG_W] != '0);
    assign fifo_pop[k]  = load && gnt_found && (gnt_ch == CHW'(k));
    // A full FIFO still takes the hit when the arbiter empties a slot this cycle
    assign drop[k]      = hit[k] && fifo_full[k] && !fifo_pop[k];
    assign fifo_push[k] = hit[k] && !drop[k];

    detect_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push[k]),
      .pop   (fifo_pop[k]),
      .din   ({bcid, det_flags[FLAG_W*k +: FLAG_W]}),
      .dout  (fifo_dout[k]),
      .empty (fifo_empty[k]),
      .full  (fifo_full[k])
    );
  end

  // ---------------------------------------------------------------------------
  // Round-robin grant: first non-empty FIFO after the last granted channel
  // ---------------------------------------------------------------------------
  assign load = !stream.o_valid || stream.o_ready;

  // NOTE: every variable of a combinational block is given a default before
  // any conditional assignment, so no path leaves it unassigned (no latch).
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_ch    = '0;
    idx       = 0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = int'(rr) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!gnt_found && !fifo_empty[idx]) begin
        gnt_found = 1'b1;
        gnt_ch    = CHW'(idx);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register; holds data and valid while stalled
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stream.o_valid <= 1'b0;
      stream.o_data  <= '0;
      rr             <= CHW'(N_CH - 1);
    end else if (load) begin
      if (gnt_found) begin
        stream.o_valid <= 1'b1;
        stream.o_data  <= {gnt_ch, fifo_dout[gnt_ch]};
        rr             <= gnt_ch;
      end else begin
        stream.o_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drop statistics
  // ---------------------------------------------------------------------------
  always_comb begin
    n_drop = '0;
    for (int k = 0; k < N_CH; k++) begin
      n_drop = n_drop + CNTW'(drop[k]);
    end
    // clr_stat restarts the count from this cycle's drops
    drop_sum = {1'b0, (clr_stat ? 16'h0000 : drop_cnt)} + 17'(n_drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt  <= '0;
      ovf_flags <= '0;
    end else begin
      drop_cnt  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      ovf_flags <= (clr_stat ? '0 : ovf_flags) | drop;
    end
  end

endmodule

// File: tb/tb_detect_arbiter.sv
// -----------------------------------------------------------------------------
// tb_detect_arbiter
// Self-checking bench for detect_arbiter. A queue-based reference model
// advances once per cycle; every record it emits goes into a scoreboard queue
// that an independent monitor drains against the DUT output stream.
// -----------------------------------------------------------------------------
module tb_detect_arbiter;
  import tmdb_mpu_pkg::*;

  localparam int N_CH       = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int BCID_W     = 12;
  localparam int BC_MAX     = 3563;
  localparam int CHW        = 3;
  localparam int ENT_W      = BCID_W + FLAG_W;
  localparam int DATA_W     = CHW + ENT_W;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [FLAG_W*N_CH-1:0] det_flags;
  logic [N_CH-1:0]        ch_en;
  logic                   bcr;
  logic                   clr_stat;
  logic [N_CH-1:0]        ovf_flags;
  logic [15:0]            drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  detect_arbiter_if #(.N_CH(N_CH), .BCID_W(BCID_W)) bus ();

  detect_arbiter #(
    .N_CH       (N_CH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .BC_MAX     (BC_MAX),
    .BCID_W     (BCID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .det_flags (det_flags),
    .ch_en     (ch_en),
    .bcr       (bcr),
    .clr_stat  (clr_stat),
    .ovf_flags (ovf_flags),
    .drop_cnt  (drop_cnt),
    .stream    (bus.master)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: per-channel queues, a one-record output slot, counters.
  // Steps at the falling edge and describes what the next rising edge does.
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0]  m_q [N_CH][$];
  logic [DATA_W-1:0] exp_q [$];
  int                m_bcid;
  int                m_rr;
  bit                m_valid;
  logic [15:0]       m_drop;
  logic [N_CH-1:0]   m_ovf;
  int                m_c;
  int                m_nd;
  bit                m_found;
  logic [N_CH-1:0]   m_dmask;
  logic [FLAG_W-1:0] m_f;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) m_q[k].delete();
      exp_q.delete();
      m_bcid  = 0;
      m_rr    = N_CH - 1;
      m_valid = 1'b0;
      m_drop  = '0;
      m_ovf   = '0;
    end else begin
      // Output slot refills when empty or when its record is being taken
      if (!m_valid || bus.o_ready) begin
        m_found = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
          m_c = (m_rr + i) % N_CH;
          if (!m_found && m_q[m_c].size() > 0) begin
            m_found = 1'b1;
            exp_q.push_back({m_c[CHW-1:0], m_q[m_c].pop_front()});
            m_rr = m_c;
          end
        end
        m_valid = m_found;
      end
      // Capture after the pop, so a full queue that just lost its head accepts
      m_dmask = '0;
      m_nd    = 0;
      for (int k = 0; k < N_CH; k++) begin
        m_f = det_flags[FLAG_W*k +: FLAG_W];
        if (ch_en[k] && m_f != 0) begin
          if (m_q[k].size() < FIFO_DEPTH) m_q[k].push_back({m_bcid[BCID_W-1:0], m_f});
          else begin
            m_dmask[k] = 1'b1;
            m_nd++;
          end
        end
      end
      if (clr_stat) begin
        m_ovf  = m_dmask;
        m_drop = 16'(m_nd);
      end else begin
        m_ovf  = m_ovf | m_dmask;
        m_drop = (int'(m_drop) + m_nd > 65535) ? 16'hFFFF : 16'(int'(m_drop) + m_nd);
      end
      if (bcr || m_bcid == BC_MAX) m_bcid = 0;
      else m_bcid = m_bcid + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares each accepted record and checks stall stability
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] prev_data;
  bit                prev_stall;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(bus.o_valid), 32'd1);
        check("stall_data", 32'(bus.o_data), 32'(prev_data));
      end
      if (bus.o_valid && bus.o_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_record: got %0h, expected no record (t=%0t)", bus.o_data, $time);
        end else begin
          check("record", 32'(bus.o_data), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = bus.o_valid && !bus.o_ready;
      prev_data  = bus.o_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
    if (rst_n) begin
      check("o_valid", 32'(bus.o_valid), 32'(m_valid));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      check("ovf_flags", 32'(ovf_flags), 32'(m_ovf));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_idle();
    det_flags = '0;
    bcr       = 1'b0;
    clr_stat  = 1'b0;
  endtask

  task automatic set_flags(input int ch, input logic [FLAG_W-1:0] f);
    det_flags[FLAG_W*ch +: FLAG_W] = f;
  endtask

  task automatic wait_bcid(input int target);
    for (int n = 0; n < 4000 && m_bcid != target; n++) tick();
    check("bcid_reached", 32'(m_bcid), 32'(target));
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n       = 1'b0;
    ch_en       = '1;
    bus.o_ready = 1'b1;
    set_idle();
    ticks(3);
    // Reset state
    check("rst_o_valid", 32'(bus.o_valid), 32'd0);
    check("rst_o_data", 32'(bus.o_data), 32'd0);
    check("rst_ovf", 32'(ovf_flags), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;

    // 1: single hit on ch3 at bcid 100, two-cycle latency
    wait_bcid(100);
    set_flags(3, 4'b0011);
    tick();
    set_idle();
    check("t1_lat_t1", 32'(bus.o_valid), 32'd0);
    tick();
    check("t1_lat_t2", 32'(bus.o_valid), 32'd1);
    check("t1_data", 32'(bus.o_data), 32'({3'd3, 12'd100, 4'b0011}));
    tick();
    check("t1_idle", 32'(bus.o_valid), 32'd0);

    // 2: simultaneous hits on ch0/ch2/ch5, twice (rr wraps back to ch0)
    for (int b = 0; b < 2; b++) begin
      set_flags(0, 4'($urandom_range(1, 15)));
      set_flags(2, 4'($urandom_range(1, 15)));
      set_flags(5, 4'($urandom_range(1, 15)));
      tick();
      set_idle();
      ticks(5);
    end

    // 3: ch1 hits 6 cycles with o_ready low -> 5 kept, 1 dropped
    bus.o_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_flags(1, 4'($urandom_range(1, 15)));
      tick();
    end
    set_idle();
    check("t3_drop", 32'(drop_cnt), 32'd1);
    check("t3_ovf", 32'(ovf_flags), 32'h02);
    ticks(3);
    bus.o_ready = 1'b1;
    ticks(8);

    // 4: bcid wrap and bcr tagging
    wait_bcid(BC_MAX);
    set_flags(6, 4'b0101);
    tick();
    set_flags(6, 4'b1010);
    tick();
    set_idle();
    ticks(4);
    wait_bcid(42);
    set_flags(7, 4'b1000);
    bcr = 1'b1;
    tick();
    bcr = 1'b0;
    set_flags(7, 4'b0100);
    tick();
    set_idle();
    ticks(4);

    // 5: disabled channel ignored; clr_stat coincident with a ch2 drop
    ch_en[4] = 1'b0;
    set_flags(4, 4'b1111);
    tick();
    set_idle();
    ticks(3);
    ch_en = '1;
    bus.o_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_flags(2, 4'($urandom_range(1, 15)));
      tick();
    end
    set_flags(2, 4'b0001);
    clr_stat = 1'b1;
    tick();
    set_idle();
    check("t5_drop", 32'(drop_cnt), 32'd1);
    check("t5_ovf", 32'(ovf_flags), 32'h04);
    bus.o_ready = 1'b1;
    ticks(8);

    // 6: reset with records buffered and o_valid high
    bus.o_ready = 1'b0;
    set_flags(2, 4'b0010);
    set_flags(5, 4'b0011);
    set_flags(6, 4'b0110);
    tick();
    set_idle();
    ticks(2);
    check("t6_pre_valid", 32'(bus.o_valid), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus.o_valid), 32'd0);
    check("t6_rst_data", 32'(bus.o_data), 32'd0);
    check("t6_rst_ovf", 32'(ovf_flags), 32'd0);
    check("t6_rst_drop", 32'(drop_cnt), 32'd0);
    ticks(2);
    rst_n = 1'b1;
    bus.o_ready = 1'b1;
    set_flags(6, 4'b1001);
    set_flags(3, 4'b0111);
    tick();
    set_idle();
    tick();
    check("t6_first_ch", 32'(bus.o_data[DATA_W-1 -: CHW]), 32'd3);
    ticks(4);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      ch_en = N_CH'($urandom);
      for (int k = 0; k < N_CH; k++)
        set_flags(k, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000);
      bus.o_ready = ($urandom_range(0, 9) < 7);
      bcr         = ($urandom_range(0, 49) == 0);
      clr_stat    = ($urandom_range(0, 29) == 0);
      tick();
    end
    set_idle();
    ch_en = '1;
    bus.o_ready = 1'b1;
    ticks(50);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(bus.o_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog timeout");
  end

endmodule
